nnl2_feeder: RTL and testbench
==============================

Name: nnl2_feeder

Overview:
- Initiator and sequencer for the 2x1 systolic dense layer (nnl2).
- Holds one 9-element input vector x, two 9-element weight rows (w1, w2) and two biases, all loaded through a simple write port.
- On `start`, drives `sys2x1_en` for exactly one 13-cycle computation window and streams operands in the order the layer expects.
- Captures the two biased results at the end of the window and presents them with a valid/done indication to the control FSM.

Parameters:
- DATA_W, 16, operand and result width (signed two's complement).
- VEC_LEN, 9, elements per vector; fixed by the layer schedule.
- CNT_W, 4, window counter width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- wr_en  in  1  write strobe for the operand banks
- wr_sel  in  2  bank select: 0=x, 1=w1, 2=w2, 3=bias (addr 0→b1, addr 1→b2)
- wr_addr  in  4  element index, 0..8
- wr_data  in  DATA_W  signed write data
- start  in  1  request one computation
- busy  out  1  high from start acceptance until the window ends
- done  out  1  one-cycle pulse when results are captured
- res1_out  out  DATA_W  captured neuron-1 result
- res2_out  out  DATA_W  captured neuron-2 result
- out_valid  out  1  results valid; cleared on the next accepted start
- sys2x1_en  out  1  enable to the layer
- in_atas  out  DATA_W  x element stream
- in_kiri_1  out  DATA_W  w1 element stream
- in_kiri_2  out  DATA_W  w2 element stream
- b1  out  DATA_W  bias 1, held for the whole window
- b2  out  DATA_W  bias 2, held for the whole window
- res1_w  in  DATA_W  layer result 1
- res2_w  in  DATA_W  layer result 2

Behaviour:
- Reset (async, rst=0):
  - All outputs 0, all banks 0, state IDLE, cnt 0.
  - Reset mid-window aborts immediately: no done pulse, out_valid=0.
- States: IDLE, STREAM, DRAIN, CAPTURE. cnt is an internal window counter mirroring the layer's main counter.
- IDLE:
  - busy=0, sys2x1_en=0.
  - start=1 at edge E0 → STREAM, cnt=0, busy=1, out_valid=0.
- STREAM (cnt 0..8):
  - sys2x1_en=1; in_atas=x[cnt], in_kiri_1=w1[cnt], in_kiri_2=w2[cnt], all registered so they change on the same edge as cnt.
  - At cnt=8 → DRAIN.
- DRAIN (cnt 9..11):
  - sys2x1_en=1; in_atas, in_kiri_1 and in_kiri_2 all 0.
  - At cnt=11 → CAPTURE.
- CAPTURE (cnt=12):
  - sys2x1_en=1, streams 0.
  - res1_w/res2_w are sampled into res1_out/res2_out on the closing edge.
  - Next state IDLE: sys2x1_en=0, busy=0, done=1 for one cycle, out_valid=1.
- Timing summary:
  - sys2x1_en is high for exactly 13 consecutive cycles (cnt 0..12), so the layer counter never reaches its wrap value and returns to 0 when enable drops.
  - b1/b2 are driven from the bias bank for the entire window and 0 otherwise.
  - Latency: start edge E0 → done high in cycle E0+14.
- Writes:
  - Accepted only when busy=0; writes while busy are ignored. wr_addr>8 is ignored.
  - wr_sel=3 with wr_addr>1 is ignored.
  - wr_en and start on the same IDLE edge: the write commits and the stream uses the new value.
- Start handling:
  - start while busy is ignored; there is no queueing.
  - start held high re-triggers on the first IDLE cycle after done. This is back-to-back operation with one idle cycle between windows.
- Arithmetic: none in this block; data is passed bit-exact, with no sign extension or saturation.

Decomposition:
- Package nnl2_pkg holds:
  - DATA_W, VEC_LEN.
  - Window thresholds: STREAM_LAST=8, DRAIN_LAST=11, CAPTURE_CNT=12.
  - wr_sel encodings: SEL_X, SEL_W1, SEL_W2, SEL_BIAS.
  - The state enum.
- Sub-module vec_bank: VEC_LEN×DATA_W register file with async active-low reset, one write port and one combinational indexed read port. Instantiated three times (x, w1, w2); the biases are two plain registers in the top module.

Test Plan:
- Load x[k]=k+1, w1[k]=2, w2[k]=-1 (0xFFFF), b1=5, b2=7; pulse start.
  - Required: sys2x1_en high for exactly 13 cycles.
  - in_atas = 1,2,…,9,0,0,0,0; in_kiri_1 = 2 for the first nine cycles, then 0; in_kiri_2 = 0xFFFF for the first nine cycles, then 0.
  - b1=5 and b2=7 for all 13 cycles.
- Behavioural layer model drives res1_w=0x1234, res2_w=0xFEDC during cnt=12.
  - Required: res1_out=0x1234, res2_out=0xFEDC, done pulse in cycle E0+14, out_valid=1.
- Write x[3]=0x7FFF while busy, plus a start pulse mid-window.
  - Required: x[3] is unchanged in the next run, the window length stays 13, and only one done pulse occurs.
- Hold start high continuously.
  - Required: two windows separated by exactly one cycle with sys2x1_en=0, each followed by a done pulse.
- Assert rst=0 at cnt=5, release, then pulse start.
  - Required: all outputs 0 immediately and no done pulse.
  - Banks are 0, so the next run streams all zeros.
- wr_en with wr_sel=0, wr_addr=4 on the same edge as start.
  - Required: the new value appears on in_atas in the cnt=4 cycle. A write to wr_addr=12 changes nothing.

Source files
------------

// File: rtl/nnl2_pkg.sv
// nnl2_pkg: shared constants and types for the nnl2 feeder slice.
//   DATA_W / VEC_LEN / CNT_W / ADDR_W : datapath, vector and counter sizing
//   STREAM_LAST / DRAIN_LAST / CAPTURE_CNT : window counter thresholds
//   SEL_*   : write-port bank select encodings
//   state_e : feeder sequencer states
package nnl2_pkg;

  localparam int DATA_W  = 16;
  localparam int VEC_LEN = 9;
  localparam int CNT_W   = 4;
  localparam int ADDR_W  = 4;

  // Window layout: cnt 0..8 stream operands, 9..11 flush the array, 12 captures.
  localparam logic [CNT_W-1:0] STREAM_LAST = 4'd8;
  localparam logic [CNT_W-1:0] DRAIN_LAST  = 4'd11;
  localparam logic [CNT_W-1:0] CAPTURE_CNT = 4'd12;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(VEC_LEN - 1);

  localparam logic [1:0] SEL_X    = 2'd0;
  localparam logic [1:0] SEL_W1   = 2'd1;
  localparam logic [1:0] SEL_W2   = 2'd2;
  localparam logic [1:0] SEL_BIAS = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_DRAIN,
    ST_CAPTURE
  } state_e;

endpackage

// File: rtl/nnl2_feeder_vec_bank.sv
// vec_bank: VEC_LEN x DATA_W operand register file.
//   clk, rst       : clock, asynchronous active-low reset (clears every entry)
//   we, waddr,     : write port; addresses beyond the last element are dropped
//   wdata
//   raddr, rdata   : combinational read; out-of-range reads return 0
module vec_bank
  import nnl2_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [CNT_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [VEC_LEN];

  // NOTE: the bank is flip-flop based and must read back as zero after reset,
  // so every entry is reset explicitly; this keeps it out of RAM inference.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < VEC_LEN; i++) mem[i] <= '0;
    end else if (we && (waddr <= LAST_ADDR)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = (raddr <= LAST_ADDR) ? mem[raddr] : '0;

endmodule

// File: rtl/nnl2_feeder.sv
// nnl2_feeder: loads operands for the 2x1 systolic dense layer, runs one
// 13-cycle enable window per accepted start and captures the two results.
//   wr_en/wr_sel/wr_addr/wr_data : operand write port (ignored while busy)
//   start                        : request a computation (ignored while busy)
//   busy, done, out_valid        : handshake to the control FSM
//   res1_out, res2_out           : results captured at the end of the window
//   sys2x1_en, in_atas,          : layer enable and operand streams
//   in_kiri_1, in_kiri_2, b1, b2
//   res1_w, res2_w               : raw layer results
module nnl2_feeder
  import nnl2_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [1:0]        wr_sel,
  input  logic [3:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] res1_out,
  output logic [DATA_W-1:0] res2_out,
  output logic              out_valid,
  output logic              sys2x1_en,
  output logic [DATA_W-1:0] in_atas,
  output logic [DATA_W-1:0] in_kiri_1,
  output logic [DATA_W-1:0] in_kiri_2,
  output logic [DATA_W-1:0] b1,
  output logic [DATA_W-1:0] b2,
  input  logic [DATA_W-1:0] res1_w,
  input  logic [DATA_W-1:0] res2_w
);

  state_e            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [DATA_W-1:0] bias1, bias2;
  logic [DATA_W-1:0] x_rd, w1_rd, w2_rd;
  logic              idle, wr_ok, start_acc;

  assign idle      = (state == ST_IDLE);
  assign wr_ok     = wr_en && idle;
  assign start_acc = start && idle;

  // Operand banks; they are only written in IDLE, so they are stable across a window.
  vec_bank u_x (
    .clk(clk), .rst(rst), .we(wr_ok && (wr_sel == SEL_X)),
    .waddr(wr_addr), .wdata(wr_data), .raddr(cnt), .rdata(x_rd)
  );
  vec_bank u_w1 (
    .clk(clk), .rst(rst), .we(wr_ok && (wr_sel == SEL_W1)),
    .waddr(wr_addr), .wdata(wr_data), .raddr(cnt), .rdata(w1_rd)
  );
  vec_bank u_w2 (
    .clk(clk), .rst(rst), .we(wr_ok && (wr_sel == SEL_W2)),
    .waddr(wr_addr), .wdata(wr_data), .raddr(cnt), .rdata(w2_rd)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bias1 <= '0;
      bias2 <= '0;
    end else if (wr_ok && (wr_sel == SEL_BIAS)) begin
      if (wr_addr == 4'd0) bias1 <= wr_data;
      if (wr_addr == 4'd1) bias2 <= wr_data;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic; cnt tracks the layer's own counter one-for-one.
  // NOTE: combinational blocks use blocking assignments and give every output
  // a default first, so no path leaves a value held and no latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 4'd1;
    unique case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (start) state_nxt = ST_STREAM;
      end
      ST_STREAM:  if (cnt == STREAM_LAST) state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (cnt == DRAIN_LAST) begin
          state_nxt = ST_CAPTURE;
          cnt_nxt   = CAPTURE_CNT;
        end
      end
      ST_CAPTURE: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs: decoded from registered state, so they move on the same edge as cnt.
  always_comb begin
    busy      = !idle;
    sys2x1_en = !idle;
    in_atas   = '0;
    in_kiri_1 = '0;
    in_kiri_2 = '0;
    b1        = '0;
    b2        = '0;
    if (state == ST_STREAM) begin
      in_atas   = x_rd;
      in_kiri_1 = w1_rd;
      in_kiri_2 = w2_rd;
    end
    if (!idle) begin
      b1 = bias1;
      b2 = bias2;
    end
  end

  // Result capture on the closing edge of the CAPTURE cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done      <= 1'b0;
      out_valid <= 1'b0;
      res1_out  <= '0;
      res2_out  <= '0;
    end else begin
      done <= (state == ST_CAPTURE);
      if (state == ST_CAPTURE) begin
        res1_out  <= res1_w;
        res2_out  <= res2_w;
        out_valid <= 1'b1;
      end else if (start_acc) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nnl2_feeder.sv
// tb_nnl2_feeder: scoreboard bench for nnl2_feeder. A transaction-level model
// turns each accepted start into thirteen expected stream beats and one
// expected result, each tagged with the cycle it must appear in; a monitor on
// the falling edge pops and compares them against what the DUT presents.
module tb_nnl2_feeder;
  import nnl2_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_sel = '0;
  logic [3:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        start = 1'b0;
  logic [15:0] res1_w = '0, res2_w = '0;
  logic        busy, done, out_valid, sys2x1_en;
  logic [15:0] res1_out, res2_out, in_atas, in_kiri_1, in_kiri_2, b1, b2;

  nnl2_feeder dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .busy(busy), .done(done),
    .res1_out(res1_out), .res2_out(res2_out), .out_valid(out_valid),
    .sys2x1_en(sys2x1_en), .in_atas(in_atas), .in_kiri_1(in_kiri_1),
    .in_kiri_2(in_kiri_2), .b1(b1), .b2(b2), .res1_w(res1_w), .res2_w(res2_w)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int          cyc;
    logic [15:0] a, k1, k2, bb1, bb2;
  } beat_t;
  typedef struct {
    int          cyc;
    logic [15:0] r1, r2;
  } res_t;

  beat_t       sq[$];
  res_t        rq[$];
  logic [15:0] mx[9], mw1[9], mw2[9], mb[2];
  int          busy_left;
  logic        ov_exp;
  logic [15:0] pend_r1, pend_r2;
  int          cap_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    sq.delete();
    rq.delete();
    busy_left = 0;
    ov_exp    = 1'b0;
    cap_cyc   = -1;
    for (int i = 0; i < 9; i++) begin
      mx[i] = '0; mw1[i] = '0; mw2[i] = '0;
    end
    mb[0] = '0;
    mb[1] = '0;
  endtask

  // Reference model: one window = 13 enabled cycles starting the cycle after
  // acceptance, results due in the cycle after the window.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) ov_exp = 1'b1;
      end else begin
        if (wr_en) begin
          case (wr_sel)
            2'd0: if (wr_addr < 9) mx[wr_addr]  = wr_data;
            2'd1: if (wr_addr < 9) mw1[wr_addr] = wr_data;
            2'd2: if (wr_addr < 9) mw2[wr_addr] = wr_data;
            default: if (wr_addr < 2) mb[wr_addr[0]] = wr_data;
          endcase
        end
        if (start) begin
          busy_left = 13;
          ov_exp    = 1'b0;
          pend_r1   = 16'($urandom);
          pend_r2   = 16'($urandom);
          cap_cyc   = cyc + 12;
          for (int k = 0; k < 13; k++) begin
            if (k < 9) sq.push_back('{cyc + k, mx[k], mw1[k], mw2[k], mb[0], mb[1]});
            else       sq.push_back('{cyc + k, 16'h0, 16'h0, 16'h0, mb[0], mb[1]});
          end
          rq.push_back('{cyc + 13, pend_r1, pend_r2});
        end
      end
    end
  end

  // Layer stand-in: the real result only during the capture cycle, junk otherwise.
  always @(negedge clk) begin
    res1_w = (cyc == cap_cyc) ? pend_r1 : 16'($urandom);
    res2_w = (cyc == cap_cyc) ? pend_r2 : 16'($urandom);
  end

  beat_t b;
  res_t  r;
  logic  exp_en, exp_done;

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      exp_en = (sq.size() > 0) && (sq[0].cyc == cyc);
      check("sys2x1_en", {31'b0, sys2x1_en}, {31'b0, exp_en});
      if (exp_en) begin
        b = sq.pop_front();
        check("in_atas",   {16'b0, in_atas},   {16'b0, b.a});
        check("in_kiri_1", {16'b0, in_kiri_1}, {16'b0, b.k1});
        check("in_kiri_2", {16'b0, in_kiri_2}, {16'b0, b.k2});
        check("b1",        {16'b0, b1},        {16'b0, b.bb1});
        check("b2",        {16'b0, b2},        {16'b0, b.bb2});
      end else begin
        check("idle_streams_zero", {31'b0, |{in_atas, in_kiri_1, in_kiri_2, b1, b2}}, 32'd0);
      end
      exp_done = (rq.size() > 0) && (rq[0].cyc == cyc);
      check("done", {31'b0, done}, {31'b0, exp_done});
      if (exp_done) begin
        r = rq.pop_front();
        check("res1_out", {16'b0, res1_out}, {16'b0, r.r1});
        check("res2_out", {16'b0, res2_out}, {16'b0, r.r2});
      end
      check("busy",      {31'b0, busy},      {31'b0, (busy_left > 0)});
      check("out_valid", {31'b0, out_valid}, {31'b0, ov_exp});
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic write(input logic [1:0] sel, input logic [3:0] addr, input logic [15:0] data);
    wr_en = 1'b1; wr_sel = sel; wr_addr = addr; wr_data = data;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    check(name, {31'b0, |{busy, done, out_valid, sys2x1_en, res1_out, res2_out,
                          in_atas, in_kiri_1, in_kiri_2, b1, b2}}, 32'd0);
  endtask

  initial begin
    model_clear();
    tick();
    check_all_zero("reset_outputs");
    tick();
    rst = 1'b1;
    tick();

    // Known vectors from the bring-up plan.
    for (int k = 0; k < 9; k++) begin
      write(2'd0, 4'(k), 16'(k + 1));
      write(2'd1, 4'(k), 16'd2);
      write(2'd2, 4'(k), 16'hFFFF);
    end
    write(2'd3, 4'd0, 16'd5);
    write(2'd3, 4'd1, 16'd7);
    pulse_start();
    repeat (16) tick();

    // Write and start attempts while busy must have no effect.
    pulse_start();
    repeat (3) tick();
    start = 1'b1;
    write(2'd0, 4'd3, 16'h7FFF);
    start = 1'b0;
    repeat (14) tick();
    pulse_start();
    repeat (16) tick();

    // start held high: back-to-back windows with one idle cycle between.
    start = 1'b1;
    repeat (40) tick();
    start = 1'b0;
    repeat (16) tick();

    // Reset at cnt=5 aborts the window and clears the banks.
    pulse_start();
    repeat (5) tick();
    #2 rst = 1'b0;
    model_clear();
    #1 check_all_zero("reset_abort_outputs");
    tick();
    tick();
    rst = 1'b1;
    tick();
    pulse_start();
    repeat (16) tick();

    // Write on the same edge as start; out-of-range address ignored.
    for (int k = 0; k < 9; k++) write(2'd0, 4'(k), 16'($urandom));
    start = 1'b1;
    write(2'd0, 4'd4, 16'hABCD);
    start = 1'b0;
    repeat (16) tick();
    write(2'd0, 4'd12, 16'h5555);
    write(2'd3, 4'd2, 16'h6666);
    pulse_start();
    repeat (16) tick();

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      start   = ($urandom_range(0, 7) == 0);
      wr_en   = $urandom_range(0, 1) == 1;
      wr_sel  = 2'($urandom);
      wr_addr = 4'($urandom_range(0, 15));
      wr_data = 16'($urandom);
      tick();
    end
    start = 1'b0;
    wr_en = 1'b0;
    repeat (20) tick();

    check("stream_queue_drained", sq.size(), 32'd0);
    check("result_queue_drained", rq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
